// File: rtl/ciaa_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ciaa_kbd_pkg
//  Description : Shared definitions for the Amiga keyboard serial stage:
//                protocol key codes, FSM state encoding and the serial
//                byte encoder (rotate left one bit, then invert).
//  Revision    : 1.0 - initial release
// ============================================================================
package ciaa_kbd_pkg;

    // Protocol codes emitted by the keyboard side on its own
    localparam logic [7:0] KC_PWRUP_START = 8'hFD;
    localparam logic [7:0] KC_PWRUP_END   = 8'hFE;
    localparam logic [7:0] KC_LOSTSYNC    = 8'hF9;

    typedef enum logic [2:0] {
        ST_PWR_FD  = 3'd0,
        ST_PWR_FE  = 3'd1,
        ST_IDLE    = 3'd2,
        ST_SEND    = 3'd3,
        ST_HS_WAIT = 3'd4,
        ST_HS_LOW  = 3'd5,
        ST_TMO     = 3'd6
    } kbd_state_t;

    // The keyboard shifts bit 6 out first and bit 7 last, active low
    function automatic logic [7:0] amiga_ser_enc(input logic [7:0] code);
        return ~{code[6:0], code[7]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ciaa_kbd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ciaa_kbd_fifo
//  Description : Synchronous 8-bit key-code FIFO, all updates on clk7_en.
//  Ports       : clk, clk7_en, reset  - clocking / synchronous reset
//                push, din            - write request and data (ignored when full)
//                pop                  - read request (ignored when empty)
//                dout                 - current head entry
//                full, empty          - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module ciaa_kbd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       clk7_en,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int             c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    // Head entry comes straight from the storage flops
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (clk7_en && w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clk7_en) begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ciaa_kbd_serial.sv
`default_nettype none
// ============================================================================
//  Module      : ciaa_kbd_serial
//  Description : Buffers Amiga raw key codes and hands them to the CIA-A SDR
//                in keyboard wire format, running the SPMODE handshake with
//                timeout / lost-sync recovery and the power-up $FD/$FE stream.
//  Ports       : clk, reset, clk7_en - clocking, synchronous reset, 7 MHz enable
//                keydat, keystrobe   - key code offered by the PS/2 decoder
//                keyack              - code accepted this tick (combinational)
//                spmode              - CIA-A CRA[6], high while CPU handshakes
//                sdr_data, sdr_load  - byte and one-tick load strobe to the SDR
//                busy                - byte in flight awaiting handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module ciaa_kbd_serial
    import ciaa_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int HS_MIN_TICKS  = 64,
    parameter int TIMEOUT_TICKS = 1014000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic [7:0] keydat,
    input  logic       keystrobe,
    output logic       keyack,
    input  logic       spmode,
    output logic [7:0] sdr_data,
    output logic       sdr_load,
    output logic       busy
);

    localparam int               c_HS_W     = $clog2(HS_MIN_TICKS + 1);
    localparam logic [c_HS_W-1:0] c_HS_MIN  = c_HS_W'(HS_MIN_TICKS);
    localparam logic [19:0]      c_TMO_LAST = 20'(TIMEOUT_TICKS - 1);

    kbd_state_t        r_state;
    kbd_state_t        r_ret;
    logic [7:0]        r_cur;
    logic [19:0]       r_timer;
    logic [c_HS_W-1:0] r_hs_cnt;
    logic              r_pwr;       // byte in flight belongs to the power-up stream
    logic [7:0]        r_sdr_data;
    logic              r_sdr_load;
    logic              r_busy;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [7:0]        w_fifo_dout;
    logic              w_pop;

    assign keyack   = keystrobe & ~w_fifo_full;
    assign w_pop    = (r_state == ST_IDLE) & ~w_fifo_empty;
    assign sdr_data = r_sdr_data;
    assign sdr_load = r_sdr_load;
    assign busy     = r_busy;

    ciaa_kbd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clk7_en (clk7_en),
        .reset   (reset),
        .push    (keystrobe),
        .din     (keydat),
        .pop     (w_pop),
        .dout    (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_PWR_FD;
            r_ret      <= ST_IDLE;
            r_cur      <= 8'h00;
            r_timer    <= '0;
            r_hs_cnt   <= '0;
            r_pwr      <= 1'b0;
            r_sdr_data <= 8'h00;
            r_sdr_load <= 1'b0;
            r_busy     <= 1'b0;
        end else if (clk7_en) begin
            r_sdr_load <= 1'b0;
            unique case (r_state)
                ST_PWR_FD: begin
                    r_sdr_data <= amiga_ser_enc(KC_PWRUP_START);
                    r_sdr_load <= 1'b1;
                    r_timer    <= '0;
                    r_busy     <= 1'b1;
                    r_pwr      <= 1'b1;
                    r_ret      <= ST_PWR_FE;
                    r_state    <= ST_HS_WAIT;
                end
                ST_PWR_FE: begin
                    r_sdr_data <= amiga_ser_enc(KC_PWRUP_END);
                    r_sdr_load <= 1'b1;
                    r_timer    <= '0;
                    r_busy     <= 1'b1;
                    r_pwr      <= 1'b1;
                    r_ret      <= ST_IDLE;
                    r_state    <= ST_HS_WAIT;
                end
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_cur   <= w_fifo_dout;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_sdr_data <= amiga_ser_enc(r_cur);
                    r_sdr_load <= 1'b1;
                    r_timer    <= '0;
                    r_busy     <= 1'b1;
                    r_pwr      <= 1'b0;
                    r_ret      <= ST_IDLE;
                    r_state    <= ST_HS_WAIT;
                end
                ST_HS_WAIT: begin
                    r_timer <= r_timer + 20'd1;
                    if (r_timer == c_TMO_LAST) begin
                        r_state <= ST_TMO;
                    end else if (spmode) begin
                        r_hs_cnt <= '0;
                        r_state  <= ST_HS_LOW;
                    end
                end
                ST_HS_LOW: begin
                    r_timer <= r_timer + 20'd1;
                    if (r_timer == c_TMO_LAST) begin
                        r_state <= ST_TMO;
                    end else if (!spmode) begin
                        // Short pulses are glitches; keep waiting on the same timer
                        if (r_hs_cnt >= c_HS_MIN) begin
                            r_busy  <= 1'b0;
                            r_state <= r_ret;
                        end else begin
                            r_state <= ST_HS_WAIT;
                        end
                    end else if (r_hs_cnt < c_HS_MIN) begin
                        r_hs_cnt <= r_hs_cnt + 1'b1;
                    end
                end
                ST_TMO: begin
                    r_sdr_load <= 1'b1;
                    r_timer    <= '0;
                    r_state    <= ST_HS_WAIT;
                    if (r_pwr) begin
                        // Power-up bytes are simply repeated, return path unchanged
                        r_sdr_data <= (r_ret == ST_PWR_FE) ? amiga_ser_enc(KC_PWRUP_START)
                                                           : amiga_ser_enc(KC_PWRUP_END);
                    end else begin
                        // Lost sync, then resend r_cur via SEND
                        r_sdr_data <= amiga_ser_enc(KC_LOSTSYNC);
                        r_ret      <= ST_SEND;
                    end
                end
                default: begin
                    r_state <= ST_PWR_FD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ciaa_kbd_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ciaa_kbd_serial
//  Description : Scoreboard bench for ciaa_kbd_serial. Stimulus queues the
//                expected SDR bytes; a monitor pops and compares on sdr_load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ciaa_kbd_serial;

    localparam int c_DEPTH = 4;
    localparam int c_HSMIN = 64;
    localparam int c_TMO   = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk7_en;
    logic [7:0] keydat;
    logic       keystrobe;
    logic       keyack;
    logic       spmode;
    logic [7:0] sdr_data;
    logic       sdr_load;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         n_loads = 0;
    int         cyc = 0;
    int         last_load_cyc = 0;
    int         prev_load_cyc = 0;
    logic       mon_prev = 1'b0;
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    ciaa_kbd_serial #(
        .FIFO_DEPTH    (c_DEPTH),
        .HS_MIN_TICKS  (c_HSMIN),
        .TIMEOUT_TICKS (c_TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk7_en   (clk7_en),
        .keydat    (keydat),
        .keystrobe (keystrobe),
        .keyack    (keyack),
        .spmode    (spmode),
        .sdr_data  (sdr_data),
        .sdr_load  (sdr_load),
        .busy      (busy)
    );

    function automatic logic [7:0] enc(input logic [7:0] c);
        return ~{c[6:0], c[7]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising sdr_load consumes one scoreboard entry
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (sdr_load === 1'b1 && !mon_prev) begin
                n_loads++;
                prev_load_cyc = last_load_cyc;
                last_load_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got %0h, expected no load", sdr_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("sdr_data", {24'h0, sdr_data}, {24'h0, mon_exp});
                end
            end
            mon_prev = (sdr_load === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic wait_loads(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_loads < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(name, n_loads, target);
    endtask

    task automatic handshake(input int len);
        @(negedge clk);
        spmode = 1'b1;
        repeat (len) @(negedge clk);
        spmode = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] c, input logic exp_ack, input logic to_sb);
        @(negedge clk);
        keydat    = c;
        keystrobe = 1'b1;
        #1;
        chk($sformatf("keyack_%02h", c), {31'h0, keyack}, {31'h0, exp_ack});
        if (exp_ack && to_sb) exp_q.push_back(enc(c));
        @(posedge clk);
        #1;
        keystrobe = 1'b0;
        keydat    = 8'h00;
    endtask

    initial begin
        reset     = 1'b1;
        clk7_en   = 1'b1;
        keystrobe = 1'b0;
        keydat    = 8'h00;
        spmode    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_keyack", {31'h0, keyack}, 0);
        chk("rst_sdr_data", {24'h0, sdr_data}, 0);
        chk("rst_sdr_load", {31'h0, sdr_load}, 0);
        chk("rst_busy", {31'h0, busy}, 0);

        // T1: power-up stream, clk7_en gating, handshakes
        exp_q.push_back(8'h04);
        reset = 1'b0;
        wait_loads(1, 20, "t1_fd_load");
        chk("t1_busy", {31'h0, busy}, 1);
        repeat (3) @(negedge clk);
        clk7_en = 1'b0;
        spmode  = 1'b1;
        repeat (100) @(negedge clk);
        spmode = 1'b0;
        repeat (5) @(negedge clk);
        clk7_en = 1'b1;
        chk("t1_gated_loads", n_loads, 1);
        chk("t1_gated_busy", {31'h0, busy}, 1);
        exp_q.push_back(8'h02);
        handshake(100);
        wait_loads(2, 20, "t1_fe_load");
        handshake(100);
        repeat (3) @(negedge clk);
        chk("t1_idle_busy", {31'h0, busy}, 0);

        // T2: latency and encoding
        push_key(8'h20, 1'b1, 1'b0);
        exp_q.push_back(8'hBF);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t2_latency_load", {31'h0, sdr_load}, 1);
        chk("t2_latency_data", {24'h0, sdr_data}, 32'hBF);
        wait_loads(3, 20, "t2_load20");
        handshake(100);
        push_key(8'hA0, 1'b1, 1'b0);
        exp_q.push_back(8'hBE);
        wait_loads(4, 20, "t2_loadA0");
        handshake(100);
        repeat (3) @(negedge clk);
        chk("t2_idle_busy", {31'h0, busy}, 0);

        // T3: timeout, lost sync, retransmit
        push_key(8'h45, 1'b1, 1'b0);
        exp_q.push_back(8'h75);
        wait_loads(5, 20, "t3_load45");
        exp_q.push_back(8'h0C);
        wait_loads(6, c_TMO + 50, "t3_lostsync");
        chk("t3_tmo_delay", last_load_cyc - prev_load_cyc, c_TMO + 1);
        exp_q.push_back(8'h75);
        handshake(100);
        wait_loads(7, 20, "t3_resend");
        handshake(100);
        repeat (3) @(negedge clk);
        chk("t3_idle_busy", {31'h0, busy}, 0);

        // T4: FIFO fill while busy, fifth push refused, order preserved
        push_key(8'h10, 1'b1, 1'b1);
        wait_loads(8, 20, "t4_load10");
        for (int i = 1; i <= 4; i++) push_key(8'h10 + 8'(i), 1'b1, 1'b1);
        push_key(8'h15, 1'b0, 1'b1);
        chk("t4_busy", {31'h0, busy}, 1);
        for (int i = 0; i < 4; i++) begin
            handshake(100);
            wait_loads(9 + i, 20, $sformatf("t4_drain%0d", i));
        end
        handshake(100);
        repeat (3) @(negedge clk);
        chk("t4_idle_busy", {31'h0, busy}, 0);

        // T5: short SPMODE pulse is ignored
        push_key(8'h33, 1'b1, 1'b1);
        wait_loads(13, 20, "t5_load33");
        handshake(10);
        repeat (5) @(negedge clk);
        chk("t5_glitch_busy", {31'h0, busy}, 1);
        chk("t5_glitch_loads", n_loads, 13);
        handshake(100);
        repeat (3) @(negedge clk);
        chk("t5_idle_busy", {31'h0, busy}, 0);
        chk("t5_loads", n_loads, 13);

        // T6: reset during HS_LOW with queued codes
        push_key(8'h50, 1'b1, 1'b1);
        wait_loads(14, 20, "t6_load50");
        push_key(8'h51, 1'b1, 1'b0);
        push_key(8'h52, 1'b1, 1'b0);
        push_key(8'h53, 1'b1, 1'b0);
        @(negedge clk);
        spmode = 1'b1;
        repeat (20) @(negedge clk);
        reset  = 1'b1;
        spmode = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("t6_rst_sdr_data", {24'h0, sdr_data}, 0);
        chk("t6_rst_sdr_load", {31'h0, sdr_load}, 0);
        chk("t6_rst_busy", {31'h0, busy}, 0);
        chk("t6_rst_keyack", {31'h0, keyack}, 0);
        exp_q.push_back(8'h04);
        reset = 1'b0;
        wait_loads(15, 20, "t6_fd_load");
        exp_q.push_back(8'h02);
        handshake(100);
        wait_loads(16, 20, "t6_fe_load");
        handshake(100);
        repeat (40) @(negedge clk);
        chk("t6_no_residue", n_loads, 16);
        chk("t6_idle_busy", {31'h0, busy}, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
